uart_rx_fsm: RTL

UART receiver. It is the receive-side counterpart of the team's uart_tx_fsm and decodes the same frame: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (XOR of the data), 1 stop bit (1). It oversamples the serial line using a tick from the shared baud generator, which runs at OVERSAMPLE × baud. Each received byte is presented with a one-cycle valid strobe and parity/framing error flags.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx_fsm.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART transmit and receive FSMs.
//   UART_DATA_W  : payload width of one frame
//   uart_state_e : frame-level state encoding (IDLE, START, DATA, PARITY, STOP)
//   even_par()   : even-parity bit of a data word (XOR of all bits)
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    PARITY = 3'b011,
    STOP   = 3'b100
  } uart_state_e;

  function automatic logic even_par(input logic [UART_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync -- multi-flop synchronizer for the asynchronous serial line.
// All stages reset to 1 so that the idle-high line does not look like a
// start bit straight out of reset.
//   clk, rst : clock, asynchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output (STAGES clk cycles of latency)
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm -- oversampling UART receiver.
// Frame: start(0), 8 data bits LSB first, even parity, stop(1).
// Optional build macro UART_RX_MAJORITY_EN: every sample point takes a 2-of-3
// vote over three consecutive ticks instead of a single sample.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   tick       : one-cycle oversample enable at OVERSAMPLE x baud
//   rx         : asynchronous serial input, idles high
//   rx_data    : last received byte, held until the next frame completes
//   rx_valid   : one-cycle strobe when rx_data/parity_err/frame_err update
//   rx_busy    : high while a frame is in progress
//   parity_err : received parity differs from even parity of rx_data
//   frame_err  : sampled stop bit was 0
//   dbg_state  : current FSM state (uart_state_e encoding)
// Handshake: rx_valid is a strobe with no ready; the consumer must capture
// rx_data and the flags on the cycle rx_valid is high (they stay held after).
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   rx,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   rx_busy,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic [2:0]             dbg_state
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(UART_DATA_W);

`ifdef UART_RX_MAJORITY_EN
  // The vote needs one tick past the target, so the decision happens one
  // tick late; data-phase targets move one tick earlier to compensate and
  // keep the bit period at OVERSAMPLE ticks.
  localparam int VOTE_LAG = 1;
  localparam int BIT_TGT  = OVERSAMPLE - 2;
`else
  localparam int VOTE_LAG = 0;
  localparam int BIT_TGT  = OVERSAMPLE - 1;
`endif

  localparam logic [CNT_W-1:0] START_DEC = CNT_W'(OVERSAMPLE / 2 - 1 + VOTE_LAG);
  localparam logic [CNT_W-1:0] BIT_DEC   = CNT_W'(BIT_TGT + VOTE_LAG);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_W - 1);

  logic rx_s;
  logic sample;

  uart_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   par_q, par_d;
  logic [UART_DATA_W-1:0] rx_data_q, rx_data_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_busy_q, rx_busy_d;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist_q[1] is rx_s two ticks ago, hist_q[0] one tick ago.
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (tick) hist_d = {hist_q[0], rx_s};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= 2'b11;
    else     hist_q <= hist_d;
  end

  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_d        = par_q;
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_valid_d   = 1'b0;        // strobe drops on the next clk regardless of tick
    rx_busy_d    = rx_busy_q;

    if (tick) begin
      cnt_d = cnt_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = START;
            rx_busy_d = 1'b1;
          end
        end
        START: begin
          if (cnt_q == START_DEC) begin
            cnt_d = '0;
            if (!sample) begin
              state_d   = DATA;
              bit_idx_d = '0;
            end else begin
              state_d   = IDLE;   // false start: glitch shorter than half a bit
              rx_busy_d = 1'b0;
            end
          end
        end
        DATA: begin
          if (cnt_q == BIT_DEC) begin
            cnt_d              = '0;
            shift_d[bit_idx_q] = sample;
            bit_idx_d          = bit_idx_q + 1'b1;
            if (bit_idx_q == IDX_LAST) state_d = PARITY;
          end
        end
        PARITY: begin
          if (cnt_q == BIT_DEC) begin
            cnt_d   = '0;
            par_d   = sample;
            state_d = STOP;
          end
        end
        STOP: begin
          if (cnt_q == BIT_DEC) begin
            cnt_d        = '0;
            rx_data_d    = shift_q;
            parity_err_d = par_q ^ even_par(shift_q);
            frame_err_d  = ~sample;
            rx_valid_d   = 1'b1;
            rx_busy_d    = 1'b0;
            state_d      = IDLE;
          end
        end
        default: begin
          cnt_d     = '0;
          rx_busy_d = 1'b0;
          state_d   = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      rx_data_q    <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_busy_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      rx_data_q    <= rx_data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      rx_valid_q   <= rx_valid_d;
      rx_busy_q    <= rx_busy_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_busy    = rx_busy_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign dbg_state  = state_q;

endmodule
